// File: rtl/fp16_accumulator_if.sv
// Product-stream handshake and result bus between a multiplier/test driver and
// fp16_accumulator.
interface fp16_accumulator_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_first;
  logic                  in_last;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [DATA_WIDTH-1:0] acc_value;

  modport master (
    output in_valid, in_data, in_first, in_last,
    input  in_ready, out_valid, out_data, acc_value
  );

  modport slave (
    input  in_valid, in_data, in_first, in_last,
    output in_ready, out_valid, out_data, acc_value
  );
endinterface

// File: rtl/fp16_accumulator.sv
// Multi-cycle FP16 running-sum accumulator (IDLE->ALIGN->ADD->NORM), one product
// per four clocks, with a one-cycle result pulse after the last product of a sum.
module fp16_accumulator #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned GUARD_BITS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  fp16_accumulator_if.slave      bus
);
  localparam int unsigned MW = 11 + GUARD_BITS;

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;
  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] a_q, b_q, acc_q, out_q;
  logic                  last_q, out_valid_q;
  logic [MW-1:0]         big_man_q, small_man_q;
  logic [4:0]            exp_q;
  logic                  sign_q, sub_q;
  logic [MW:0]           sum_q;

  logic [4:0]            ea, eb, big_e, small_e, diff;
  logic [MW-1:0]         ma, mb, big_m, small_m, small_sh;
  logic                  a_big;
  logic [4:0]            lz;
  logic                  found;
  logic [MW-1:0]         norm_man;
  logic signed [6:0]     exp_n;
  logic [DATA_WIDTH-1:0] result;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign bus.acc_value = acc_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      default: state_d = IDLE;
    endcase
  end

  // Alignment: an exponent field of 0 means zero, so its mantissa has no hidden bit.
  always_comb begin
    ea       = a_q[14:10];
    eb       = b_q[14:10];
    ma       = (ea == '0) ? '0 : {1'b1, a_q[9:0], {GUARD_BITS{1'b0}}};
    mb       = (eb == '0) ? '0 : {1'b1, b_q[9:0], {GUARD_BITS{1'b0}}};
    a_big    = (ea > eb) || ((ea == eb) && (ma >= mb));
    big_e    = a_big ? ea : eb;
    small_e  = a_big ? eb : ea;
    big_m    = a_big ? ma : mb;
    small_m  = a_big ? mb : ma;
    diff     = big_e - small_e;
    small_sh = (diff >= 5'(MW)) ? '0 : (small_m >> diff);
  end

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MW; i++) begin
      if (!found && sum_q[MW-1-i]) begin
        lz    = 5'(i);
        found = 1'b1;
      end
    end
    if (sum_q[MW]) begin
      norm_man = sum_q[MW:1];
      exp_n    = $signed({2'b00, exp_q}) + 7'sd1;
    end else begin
      norm_man = sum_q[MW-1:0] << lz;
      exp_n    = $signed({2'b00, exp_q}) - $signed({2'b00, lz});
    end
    if ((sum_q == '0) || (exp_n <= 7'sd0))
      result = '0;
    else if (exp_n >= 7'sd31)
      result = {sign_q, 5'h1E, 10'h3FF};
    else
      result = {sign_q, exp_n[4:0], norm_man[MW-2 -: 10]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      big_man_q   <= '0;
      small_man_q <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q    <= bus.in_first ? '0 : acc_q;
          b_q    <= bus.in_data;
          last_q <= bus.in_last;
        end
        ALIGN: begin
          big_man_q   <= big_m;
          small_man_q <= small_sh;
          exp_q       <= big_e;
          sign_q      <= a_big ? a_q[15] : b_q[15];
          sub_q       <= a_q[15] ^ b_q[15];
        end
        ADD: sum_q <= sub_q ? {1'b0, big_man_q - small_man_q}
                            : {1'b0, big_man_q} + {1'b0, small_man_q};
        default: begin
          acc_q <= result;
          if (last_q) begin
            out_q       <= result;
            out_valid_q <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp16_accumulator.sv
// Directed checks of fp16_accumulator: latency, handshake, rounding-free sums,
// cancellation, alignment underflow, saturation, flush, and reset abort.
module tb_fp16_accumulator;
  logic clk = 1'b0;
  logic reset;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned accepts = 0;
  int unsigned pulses = 0;

  fp16_accumulator_if #(.DATA_WIDTH(16)) bus ();

  fp16_accumulator #(.DATA_WIDTH(16), .GUARD_BITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) accepts++;
    if (bus.out_valid) pulses++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at #1 after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] d, input logic f, input logic l);
    int unsigned n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_wait", 16'(bus.in_ready), 16'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_first = f;
    bus.in_last  = l;
    tick();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Follows one accepted product through its three remaining clocks.
  task automatic item(input string tag, input logic [15:0] d, input logic f,
                      input logic l, input logic [15:0] exp);
    send(d, f, l);
    for (int k = 1; k <= 3; k++) begin
      if (k < 3) tick();
      else tick();
      check({tag, "_ready"}, 16'(bus.in_ready), (k == 3) ? 16'd1 : 16'd0);
      check({tag, "_valid"}, 16'(bus.out_valid), (k == 3) ? 16'(l) : 16'd0);
    end
    check({tag, "_acc"}, bus.acc_value, exp);
    if (l) begin
      check({tag, "_out"}, bus.out_data, exp);
      tick();
      check({tag, "_pulse_end"}, 16'(bus.out_valid), 16'd0);
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_ready", 16'(bus.in_ready), 16'd1);
    check("rst_valid", 16'(bus.out_valid), 16'd0);
    check("rst_out", bus.out_data, 16'h0000);
    check("rst_acc", bus.acc_value, 16'h0000);

    item("one", 16'h3C00, 1'b1, 1'b1, 16'h3C00);

    item("seq_a", 16'h3C00, 1'b1, 1'b0, 16'h3C00);
    item("seq_b", 16'h4000, 1'b0, 1'b0, 16'h4200);
    item("seq_c", 16'h3800, 1'b0, 1'b1, 16'h4300);

    item("cancel_a", 16'h3C00, 1'b1, 1'b0, 16'h3C00);
    item("cancel_b", 16'hBC00, 1'b0, 1'b1, 16'h0000);

    item("sub_a", 16'h4200, 1'b1, 1'b0, 16'h4200);
    item("sub_b", 16'hBC00, 1'b0, 1'b1, 16'h4000);
    item("cont", 16'h3C00, 1'b0, 1'b1, 16'h4200);

    item("neg_a", 16'hC000, 1'b1, 1'b0, 16'hC000);
    item("neg_b", 16'h3C00, 1'b0, 1'b1, 16'hBC00);

    item("tiny_a", 16'h6400, 1'b1, 1'b0, 16'h6400);
    item("tiny_b", 16'h0400, 1'b0, 1'b1, 16'h6400);

    item("sat_a", 16'h7BFF, 1'b1, 1'b0, 16'h7BFF);
    item("sat_b", 16'h7BFF, 1'b0, 1'b1, 16'h7BFF);
    item("satn_a", 16'hFBFF, 1'b1, 1'b0, 16'hFBFF);
    item("satn_b", 16'hFBFF, 1'b0, 1'b1, 16'hFBFF);

    item("flush_a", 16'h0500, 1'b1, 1'b0, 16'h0500);
    item("flush_b", 16'h8400, 1'b0, 1'b1, 16'h0000);
    item("negzero", 16'h8000, 1'b1, 1'b1, 16'h0000);

    // Reset lands on the edge that would leave ADD.
    item("pre_rst", 16'h4000, 1'b1, 1'b1, 16'h4000);
    pulses = 0;
    send(16'h3C00, 1'b0, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_acc", bus.acc_value, 16'h0000);
    check("abort_ready", 16'(bus.in_ready), 16'd1);
    for (int k = 0; k < 5; k++) tick();
    check("abort_pulses", 16'(pulses), 16'd0);
    check("abort_out", bus.out_data, 16'h0000);

    accepts = 0;
    pulses  = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h3C00;
    bus.in_first = 1'b1;
    bus.in_last  = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("hold_accepts", 16'(accepts), 16'd3);
    check("hold_pulses", 16'(pulses), 16'd3);
    check("hold_acc", bus.acc_value, 16'h3C00);

    item("fresh", 16'h4000, 1'b1, 1'b1, 16'h4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
